mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one DATA_W-bit result path between 8 requesters.
//  Owns the 3-bit select of an internal 8:1 mux; a granted requester keeps the path
//  until it drops req. Sits between the execution units and the shared write-back path.
// PARAMETERS
//  DATA_W   32  width of each requester's data word and of out_data
//  TIMEOUT  16  max cycles a grant is held (only with MUX_ARB_TIMEOUT_EN); legal 2..65535
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         synchronous reset, active-high
//  req       in   8         request per requester; hold high while using the path
//  in_data   in   8*DATA_W  requester i drives bits [i*DATA_W +: DATA_W]
//  grant     out  8         one-hot grant, registered; all-zero when idle
//  sel       out  3         index of current owner, registered; drives the mux
//  busy      out  1         registered; high while a grant is held
//  out_data  out  DATA_W    in_data slice selected by sel (combinational); 0 when !busy
//  timeout   out  1         one-cycle pulse on forced revoke; tied 0 without the macro
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, sel=0, busy=0, timeout=0, ptr=7, hold counter=0.
//    With ptr=7 after reset, requester 0 has first priority.
//  - IDLE:
//    - if req!=0, pick the first set bit scanning ptr+1, ptr+2, ... ptr+8 (mod 8).
//    - Registers grant, sel, busy and ptr=winner on that edge; next state BUSY.
//    - Latency: req sampled high at edge N -> grant visible after edge N.
//  - BUSY:
//    - Holds while req[sel]=1; req changes on other lines are ignored.
//    - When req[sel]=0 at an edge: grant=0, busy=0, next state IDLE. One idle cycle
//      follows every release; the next grant comes after the following edge.
//    - The releasing requester has lowest priority in the next arbitration (ptr=sel).
//  - Arbitration uses only req; in_data is never registered.
//  - Owner dropping and another raising req at the same edge: release first; the other
//    is granted one cycle later.
//  - rst wins over all events, including mid-grant: the grant is dropped on that edge.
//  - The grant is always one-hot or zero; sel==index(grant) whenever busy=1.
// CONFIGURATION
//  MUX_ARB_TIMEOUT_EN defined:
//   - A 16-bit hold counter clears on grant and increments each BUSY cycle.
//   - When the counter reaches TIMEOUT-1 with req[sel] still 1, the grant is forced off
//     on that edge: timeout=1 for one cycle, next state IDLE, ptr=sel.
//   - A still-requesting owner re-wins only if no other req is set.
//  MUX_ARB_TIMEOUT_EN undefined:
//   - No counter; timeout is constant 0; a grant is held indefinitely.
// TESTING
//  1 rst=1 for 2 cycles with req=8'hFF -> grant=0, sel=0, busy=0, out_data=0 throughout.
//  2 req=8'h10, in_data slice4=32'hDEADBEEF -> after 1 edge grant=8'h10, sel=4,
//    out_data=32'hDEADBEEF.
//  3 req=8'hFF, each owner drops req for 1 cycle after 2 cycles held -> grants in order
//    01,02,04,...,80,01; exactly 1 idle cycle between grants.
//  4 owner 2 drops req while req[5] rises at the same edge -> busy=0 for 1 cycle,
//    then grant=8'h20.
//  5 rst pulsed while grant=8'h08 -> next cycle grant=0; with req=8'h09 afterwards the
//    winner is 0 (ptr reset).
//  6 macro on, TIMEOUT=4, req=8'h03 held -> grant 01 for 4 cycles, timeout pulse,
//    idle cycle, grant 02.
//    Macro off, same stimulus -> grant 01 held, timeout=0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 DATA_W-bit mux; an owner keeps the path until it drops req.
// Optional grant-hold limit enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            req,
    input  logic [8*DATA_W-1:0]   in_data,
    output logic [7:0]            grant,
    output logic [2:0]            sel,
    output logic                  busy,
    output logic [DATA_W-1:0]     out_data,
    output logic                  timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  grant_q, grant_d;
    logic [2:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        found;
    logic [2:0]  win;
    logic        expire;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mux_rr_arbiter: TIMEOUT must be in 2..65535");
    end

    // Scan starts just after the last owner, so it ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] idx;
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 8'(1) << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    ptr_d   = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req[sel_q] || expire) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= 3'd7;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // Counter is zero on the first BUSY cycle, so the owner gets exactly TIMEOUT cycles.
    assign expire    = (state_q == BUSY) && req[sel_q] && (cnt_q == 16'(TIMEOUT - 1));
    assign cnt_d     = (state_q == BUSY) ? cnt_q + 16'd1 : '0;
    assign timeout_d = expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign out_data = busy_q ? in_data[sel_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed table-driven bench for mux_rr_arbiter, plus hand-written reset and hold-limit sequences.
module tb_mux_rr_arbiter;

    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        req = '0;
    logic [8*DW-1:0]   in_data;
    logic [7:0]        grant;
    logic [2:0]        sel;
    logic              busy;
    logic [DW-1:0]     out_data;
    logic              timeout;

    mux_rr_arbiter #(.DATA_W(DW), .TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in_data  (in_data),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .out_data (out_data),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic       t;
        logic       chk_s;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] slice[8];
    int            n_run  = 0;
    int            n_fail = 0;

    function automatic vec_t mk(logic r, logic [7:0] rq, logic [7:0] g, logic [2:0] s,
                                logic b, logic t, logic cs);
        vec_t v;
        v.rst = r; v.req = rq; v.g = g; v.s = s; v.b = b; v.t = t; v.chk_s = cs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                              input logic b, input logic t, input logic cs);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        if (cs) chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".data"}, out_data, b ? slice[s] : '0);
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            slice[i] = 32'hC0DE_0000 | (32'(i) << 8) | 32'(i * 17);
        end
        slice[4] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = slice[i];

        // Reset held with every line requesting
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 0, 0, 0, 1));
        // Single requester 4, held then released
        vecs.push_back(mk(0, 8'h10, 8'h10, 4, 1, 0, 1));
        vecs.push_back(mk(0, 8'h10, 8'h10, 4, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0));
        // Full rotation from a fresh pointer
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 1));
        for (int k = 0; k < 8; k++) begin
            logic [7:0] one;
            one = 8'(1) << k;
            vecs.push_back(mk(0, 8'hFF, one, 3'(k), 1, 0, 1));
            vecs.push_back(mk(0, 8'hFF, one, 3'(k), 1, 0, 1));
            vecs.push_back(mk(0, ~one, 8'h00, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 8'hFF, 8'h01, 0, 1, 0, 1));
        // Owner 2 releases as 5 rises; other lines ignored while held
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h04, 8'h04, 2, 1, 0, 1));
        vecs.push_back(mk(0, 8'h0F, 8'h04, 2, 1, 0, 1));
        vecs.push_back(mk(0, 8'h20, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h20, 8'h20, 5, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            expect_out($sformatf("v%0d", i), vecs[i].g, vecs[i].s, vecs[i].b, vecs[i].t,
                       vecs[i].chk_s);
        end

        // Reset mid-grant drops the grant and restores requester 0 priority
        step(1, 8'h00);
        step(0, 8'h08);
        expect_out("rst_mid.a", 8'h08, 3, 1, 0, 1);
        step(1, 8'h08);
        expect_out("rst_mid.b", 8'h00, 0, 0, 0, 1);
        step(0, 8'h09);
        expect_out("rst_mid.c", 8'h01, 0, 1, 0, 1);

        // Hold limit with two persistent requesters
        step(1, 8'h00);
        for (int c = 0; c < 4; c++) begin
            step(0, 8'h03);
            expect_out($sformatf("hold.c%0d", c), 8'h01, 0, 1, 0, 1);
        end
        step(0, 8'h03);
`ifdef MUX_ARB_TIMEOUT_EN
        expect_out("hold.revoke", 8'h00, 0, 0, 1, 0);
        step(0, 8'h03);
        expect_out("hold.next", 8'h02, 1, 1, 0, 1);
`else
        expect_out("hold.c4", 8'h01, 0, 1, 0, 1);
        step(0, 8'h03);
        expect_out("hold.c5", 8'h01, 0, 1, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
